signed_div_sequencer: RTL and testbench

- Multi-cycle controller that performs signed division using an unsigned array divider.
- Converts the operands to magnitudes, drives the external unsigned divider for a fixed latency, then restores the signs of quotient and remainder.
- Uses exactly one internal TwosComplement (N-bit) instance, time-shared across four conversion steps. The block sits between the ALU operation decoder and the ArrayDivider datapath.

---
 rtl/signed_div_sequencer.sv | 146 ++++++++++++++
 tb/tb_signed_div_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/signed_div_sequencer.sv
// Signed division controller around an external unsigned array divider.
// One shared two's-complement negator handles both operand and both result sign fixes.

module twos_complement #(
  parameter int N = 8
) (
  input  logic [N-1:0] in,
  input  logic         flip,
  output logic [N-1:0] out
);
  assign out = flip ? ((~in) + {{(N-1){1'b0}}, 1'b1}) : in;
endmodule

module signed_div_sequencer #(
  parameter int N       = 8,
  parameter int DIV_LAT = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  output logic         Ready,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic [N-1:0] Div_A,
  output logic [N-1:0] Div_B,
  input  logic [N-1:0] Div_Q,
  input  logic [N-1:0] Div_R,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         Done,
  output logic         DivByZero,
  output logic         Overflow
);
  localparam int CW = $clog2(DIV_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, NEG_A, NEG_B, DIV, FIX_Q, FIX_R, DONE
  } state_t;

  state_t        state, next;
  logic [N-1:0]  a_l, b_l, q_c, r_c;
  logic          sa, sb;
  logic [CW-1:0] cnt;
  logic [N-1:0]  neg_in, neg_out;
  logic          neg_flip;

  twos_complement #(.N(N)) u_neg (
    .in   (neg_in),
    .flip (neg_flip),
    .out  (neg_out)
  );

  // Negator steering doubles as next-state logic; unused states park it at 0.
  always_comb begin
    next     = state;
    neg_in   = '0;
    neg_flip = 1'b0;
    case (state)
      IDLE:  if (Start) next = NEG_A;
      NEG_A: begin
        neg_in   = a_l;
        neg_flip = sa;
        next     = NEG_B;
      end
      NEG_B: begin
        neg_in   = b_l;
        neg_flip = sb;
        next     = (neg_out == '0) ? DONE : DIV;
      end
      DIV:   if (cnt == CW'(1)) next = FIX_Q;
      FIX_Q: begin
        neg_in   = q_c;
        neg_flip = sa ^ sb;
        next     = FIX_R;
      end
      FIX_R: begin
        neg_in   = r_c;
        neg_flip = sa;
        next     = DONE;
      end
      DONE:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      a_l       <= '0;
      b_l       <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      q_c       <= '0;
      r_c       <= '0;
      cnt       <= '0;
      Div_A     <= '0;
      Div_B     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      state <= next;
      case (state)
        IDLE: if (Start) begin
          a_l       <= Dividend;
          b_l       <= Divisor;
          sa        <= Dividend[N-1];
          sb        <= Divisor[N-1];
          DivByZero <= 1'b0;
          Overflow  <= 1'b0;
        end
        NEG_A: Div_A <= neg_out;
        NEG_B: begin
          Div_B <= neg_out;
          if (neg_out == '0) begin
            Quotient  <= '1;
            Remainder <= a_l;
            DivByZero <= 1'b1;
          end else begin
            cnt <= CW'(DIV_LAT);
          end
        end
        DIV: begin
          if (cnt == CW'(1)) begin
            q_c <= Div_Q;
            r_c <= Div_R;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        FIX_Q: Quotient <= neg_out;
        FIX_R: begin
          Remainder <= neg_out;
          // Most-negative / -1 wraps naturally to most-negative; only the flag is extra.
          Overflow  <= (a_l == {1'b1, {(N-1){1'b0}}}) && (b_l == '1);
        end
        default: ;
      endcase
    end
  end

  assign Ready = (state == IDLE);
  assign Done  = (state == DONE);

endmodule

// File: tb/tb_signed_div_sequencer.sv
// Directed bench for signed_div_sequencer: two instances (DIV_LAT=1 and 3) with
// behavioural unsigned dividers and a queue of expected results.

module tb_signed_div_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, ready0, done0, dbz0, ov0;
  logic [7:0] dd0, dv0, da0, db0, dq0, dr0, q0, r0;
  logic       start1, ready1, done1, dbz1, ov1;
  logic [7:0] dd1, dv1, da1, db1, dq1, dr1, q1, r1;

  assign dq0 = (db0 == 8'h00) ? 8'hFF : da0 / db0;
  assign dr0 = (db0 == 8'h00) ? da0   : da0 % db0;
  assign dq1 = (db1 == 8'h00) ? 8'hFF : da1 / db1;
  assign dr1 = (db1 == 8'h00) ? da1   : da1 % db1;

  signed_div_sequencer #(.N(8), .DIV_LAT(1)) u0 (
    .Clk(clk), .Reset(rst), .Start(start0), .Ready(ready0),
    .Dividend(dd0), .Divisor(dv0), .Div_A(da0), .Div_B(db0),
    .Div_Q(dq0), .Div_R(dr0), .Quotient(q0), .Remainder(r0),
    .Done(done0), .DivByZero(dbz0), .Overflow(ov0)
  );

  signed_div_sequencer #(.N(8), .DIV_LAT(3)) u1 (
    .Clk(clk), .Reset(rst), .Start(start1), .Ready(ready1),
    .Dividend(dd1), .Divisor(dv1), .Div_A(da1), .Div_B(db1),
    .Div_Q(dq1), .Div_R(dr1), .Quotient(q1), .Remainder(r1),
    .Done(done1), .DivByZero(dbz1), .Overflow(ov1)
  );

  typedef struct {
    logic [7:0] q, r, a, b;
    logic       dbz, ov;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] dd, input logic [7:0] dv, input int lat);
    exp_t e;
    int   a, b;
    a     = $signed(dd);
    b     = $signed(dv);
    e.a   = 8'(a < 0 ? -a : a);
    e.b   = 8'(b < 0 ? -b : b);
    e.dbz = 1'b0;
    e.ov  = 1'b0;
    e.lat = lat + 4;
    if (b == 0) begin
      e.q = 8'hFF; e.r = dd; e.dbz = 1'b1; e.lat = 2;
    end else if (a == -128 && b == -1) begin
      e.q = 8'h80; e.r = 8'h00; e.ov = 1'b1;
    end else begin
      e.q = 8'(a / b);
      e.r = 8'(a % b);
    end
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e, input int n,
                         input logic [7:0] q, input logic [7:0] r, input logic [7:0] a,
                         input logic [7:0] b, input logic dbz, input logic ov);
    chk({tag, "_lat"}, n, e.lat);
    chk({tag, "_q"}, q, e.q);
    chk({tag, "_r"}, r, e.r);
    chk({tag, "_diva"}, a, e.a);
    chk({tag, "_divb"}, b, e.b);
    chk({tag, "_dbz"}, dbz, e.dbz);
    chk({tag, "_ov"}, ov, e.ov);
  endtask

  // One operation on u0; optionally pulses Start while the DUT sits in DIV.
  task automatic op0(input string tag, input logic [7:0] dd, input logic [7:0] dv, input bit pulse);
    exp_t e;
    int   n;
    @(negedge clk);
    chk({tag, "_ready"}, ready0, 1);
    start0 = 1'b1; dd0 = dd; dv0 = dv;
    sb.push_back(model(dd, dv, 1));
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 0;
    while (!done0 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (pulse && n == 2) begin
        start0 = 1'b1; dd0 = 8'h63; dv0 = 8'h05;
      end else begin
        start0 = 1'b0;
      end
    end
    e = sb.pop_front();
    compare(tag, e, n, q0, r0, da0, db0, dbz0, ov0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done0, 0);
    chk({tag, "_idle"}, ready0, 1);
    chk({tag, "_q_hold"}, q0, e.q);
  endtask

  logic [7:0] bb_dd [3];
  logic [7:0] bb_dv [3];

  initial begin
    exp_t e;
    int   n;
    rst = 1'b1;
    start0 = 1'b0; dd0 = '0; dv0 = '0;
    start1 = 1'b0; dd1 = '0; dv1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready0, 1);
    chk("rst_done", done0, 0);
    chk("rst_q", q0, 0);
    chk("rst_r", r0, 0);
    chk("rst_diva", da0, 0);
    chk("rst_divb", db0, 0);
    chk("rst_flags", {dbz0, ov0}, 0);
    rst = 1'b0;

    op0("p7_2",   8'h07, 8'h02, 0);
    op0("m7_2",   8'hF9, 8'h02, 0);
    op0("p7_m2",  8'h07, 8'hFE, 0);
    op0("m7_m2",  8'hF9, 8'hFE, 0);
    op0("ovf",    8'h80, 8'hFF, 0);
    op0("dbz",    8'h25, 8'h00, 0);
    op0("m128_3", 8'h80, 8'h03, 0);
    op0("ign",    8'h64, 8'h07, 1);

    // Abort an operation mid-flight with reset.
    @(negedge clk);
    start0 = 1'b1; dd0 = 8'h07; dv0 = 8'h03;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", ready0, 1);
    chk("abort_done", done0, 0);
    chk("abort_q", q0, 0);
    chk("abort_r", r0, 0);
    chk("abort_div", {da0, db0}, 0);
    chk("abort_flags", {dbz0, ov0}, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_nodone", done0, 0);
    end
    op0("p9_3", 8'h09, 8'h03, 0);

    // Back-to-back on the DIV_LAT=3 instance with Start held high.
    bb_dd[0] = 8'h64; bb_dv[0] = 8'h07;
    bb_dd[1] = 8'hCE; bb_dv[1] = 8'h06;
    bb_dd[2] = 8'h11; bb_dv[2] = 8'hFB;
    @(negedge clk);
    chk("bb_ready0", ready1, 1);
    start1 = 1'b1; dd1 = bb_dd[0]; dv1 = bb_dv[0];
    for (int k = 0; k < 3; k++) begin
      sb.push_back(model(bb_dd[k], bb_dv[k], 3));
      @(posedge clk); #1;
      n = 0;
      while (!done1 && n < 40) begin
        @(posedge clk); #1;
        n++;
        chk("bb_ready_low", ready1, 0);
      end
      e = sb.pop_front();
      compare("bb", e, n, q1, r1, da1, db1, dbz1, ov1);
      if (k < 2) begin
        dd1 = bb_dd[k+1]; dv1 = bb_dv[k+1];
      end
      @(posedge clk); #1;
      chk("bb_done_pulse", done1, 0);
      chk("bb_idle", ready1, 1);
    end
    start1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
